// File: rtl/mainbus_arbiter.sv
// rtl/mainbus_arbiter.sv - MainBus sequencer/arbiter for Dragon-protocol cache controllers.
// Fixed-priority arbitration by default; define MAINBUS_ROUND_ROBIN_EN for round-robin.
module mainbus_arbiter #(
    parameter int NUM_CACHES  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CACHES-1:0]         req,
    input  logic [2*NUM_CACHES-1:0]       req_op,
    input  logic [NUM_CACHES-1:0]         snoop_shared,
    output logic [NUM_CACHES-1:0]         gnt,
    output logic [NUM_CACHES-1:0]         done,
    output logic [$clog2(NUM_CACHES)-1:0] owner,
    output logic                          bus_rd,
    output logic                          bus_upd,
    output logic                          mem_re,
    output logic                          mem_we,
    output logic                          shared_out,
    output logic                          busy
);

    localparam int OW = $clog2(NUM_CACHES);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [1:0] OP_RD    = 2'b00;
    localparam logic [1:0] OP_UPD   = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    generate
        if (NUM_CACHES < 2 || NUM_CACHES > 8) begin : g_bad_num_caches
            $error("mainbus_arbiter: NUM_CACHES must be in 2..8");
        end
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_mem_latency
            $error("mainbus_arbiter: MEM_LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SNOOP,
        S_MEM,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [OW-1:0]           owner_n;
    logic [1:0]              op_q;
    logic [1:0]              op_n;
    logic [OW-1:0]           last_owner;
    logic [CW-1:0]           mem_cnt;
    logic [NUM_CACHES-1:0]   eligible;
    logic                    found;
    logic [OW-1:0]           winner;
    logic                    busy_n;
    logic [NUM_CACHES-1:0]   own_mask;
    logic [NUM_CACHES-1:0]   own_mask_n;

    // Reserved ops are invisible to arbitration.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            eligible[i] = req[i] && (req_op[2*i +: 2] != OP_RSVD);
        end
    end

`ifdef MAINBUS_ROUND_ROBIN_EN
    logic [OW-1:0] rr_idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = '0;
        for (int k = 1; k <= NUM_CACHES; k++) begin
            rr_idx = OW'((int'(last_owner) + k) % NUM_CACHES);
            if (!found && eligible[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end
`else
    // Pointer is still tracked so both builds keep the same state.
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (!found && eligible[i]) begin
                found  = 1'b1;
                winner = OW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_n = state;
        owner_n = owner;
        op_n    = op_q;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n = S_GRANT;
                    owner_n = winner;
                    op_n    = req_op[{winner, 1'b0} +: 2];
                end
            end
            S_GRANT: state_n = S_SNOOP;
            S_SNOOP: state_n = (op_q == OP_UPD) ? S_DONE : S_MEM;
            S_MEM: begin
                if (mem_cnt == CW'(1)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign busy_n     = (state_n != S_IDLE);
    assign own_mask   = NUM_CACHES'(1) << owner;
    assign own_mask_n = NUM_CACHES'(1) << owner_n;

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner      <= '0;
            op_q       <= OP_RD;
            last_owner <= OW'(NUM_CACHES - 1);
            mem_cnt    <= '0;
            gnt        <= '0;
            done       <= '0;
            bus_rd     <= 1'b0;
            bus_upd    <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            shared_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            owner   <= owner_n;
            op_q    <= op_n;
            busy    <= busy_n;
            gnt     <= busy_n ? own_mask_n : '0;
            done    <= (state_n == S_DONE) ? own_mask_n : '0;
            bus_rd  <= busy_n && (op_n == OP_RD);
            bus_upd <= busy_n && (op_n == OP_UPD);
            mem_re  <= (state_n == S_MEM) && (op_n == OP_RD);
            mem_we  <= (state_n == S_MEM) && (op_n == OP_FLUSH);

            if (state == S_SNOOP) begin
                shared_out <= |(snoop_shared & ~own_mask);
            end else if (state_n == S_IDLE) begin
                shared_out <= 1'b0;
            end

            if (state == S_SNOOP) begin
                mem_cnt <= CW'(MEM_LATENCY);
            end else if (state == S_MEM) begin
                mem_cnt <= mem_cnt - CW'(1);
            end

            if (state == S_DONE) begin
                last_owner <= owner;
            end
        end
    end

endmodule
